// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply or restoring divide, one iteration per cycle over XLEN cycles.
// Signed operations run on operand magnitudes; the sign is fixed up when the result is loaded.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    M-extension instruction present in EX (sampled only in IDLE)
//   funct3_i   000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//   rs1_val_i  operand A (multiplicand / dividend)
//   rs2_val_i  operand B (multiplier / divisor)
//   flush_i    pipeline redirect; aborts the operation in flight
//   stall_o    combinational freeze request for IF/ID/EX
//   busy_o     state != IDLE
//   done_o     result valid this cycle
//   result_o   registered result, valid while done_o=1
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   When defined, divide-by-zero and multiply-by-zero go straight from IDLE to DONE.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic [XLEN-1:0] rs2_val_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Select the requested half/field of the accumulator and apply the sign fix.
    function automatic logic [XLEN-1:0] fix_result(input logic [2:0] op, input logic neg,
                                                   input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   field;
        if (!op[2]) begin
            prod = neg ? -acc : acc;
            return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        field = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        return neg ? -field : field;
    endfunction

    // Operand decode for the start cycle
    logic            is_div;
    logic            a_signed, b_signed;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            neg_start;

    always_comb begin
        is_div    = funct3_i[2];
        // Divide: DIV/REM signed. Multiply: A signed unless MULHU, B signed only for MUL/MULH.
        a_signed  = is_div ? !funct3_i[0] : (funct3_i[1:0] != 2'b11);
        b_signed  = is_div ? !funct3_i[0] : !funct3_i[1];
        sign_a    = a_signed & rs1_val_i[XLEN-1];
        sign_b    = b_signed & rs2_val_i[XLEN-1];
        mag_a     = sign_a ? -rs1_val_i : rs1_val_i;
        mag_b     = sign_b ? -rs2_val_i : rs2_val_i;
        // Remainder follows the dividend; everything else follows the sign product.
        neg_start = (funct3_i[2:1] == 2'b11) ? sign_a : (sign_a ^ sign_b);
    end

    // One iteration of each datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_acc;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = rem_sh - {1'b0, opnd_q};
        // Restoring step: keep the shifted remainder when the trial subtraction goes negative.
        div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step_acc = op_q[2] ? div_next : mul_next;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic              zero_start;
    logic [2*XLEN-1:0] early_acc;

    always_comb begin
        zero_start = is_div ? (rs2_val_i == '0) : ((rs1_val_i == '0) || (rs2_val_i == '0));
        // What the full iteration would leave: quotient all ones, remainder |A|; product zero.
        early_acc  = is_div ? {mag_a, {XLEN{1'b1}}} : {2*XLEN{1'b0}};
    end
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d    = funct3_i;
                    neg_d   = neg_start;
                    opnd_d  = is_div ? mag_b : mag_a;
                    acc_d   = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                    count_d = '0;
                    state_d = StRun;
`ifdef MULDIV_EARLY_OUT_EN
                    if (zero_start) begin
                        state_d  = StDone;
                        result_d = fix_result(funct3_i, neg_start, early_acc);
                    end
`endif
                end
            end
            StRun: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == CntW'(XLEN - 1)) begin
                    state_d  = StDone;
                    result_d = fix_result(op_q, neg_q, step_acc);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign stall_o  = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StRun);
    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .funct3_i  (funct3),
        .rs1_val_i (rs1_val),
        .rs2_val_i (rs2_val),
        .flush_i   (flush),
        .stall_o   (stall),
        .busy_o    (busy),
        .done_o    (done),
        .result_o  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] ? (b == 0) : (a == 0 || b == 0)) return 1;
`endif
        return 33;
    endfunction

    // Issue one op; start is sampled at edge 0 and cycle c is the c-th negedge after it.
    // With hold set, start stays high through RUN/DONE with different operands.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int          lat;
        int          stalls;
        logic [31:0] res;
        bit          stall_at_done;
        int          exp_lat;
        lat = -1;
        res = 32'h0;
        stall_at_done = 1'b0;
        exp_lat = exp_latency(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b;
        #1;
        stalls = stall ? 1 : 0;
        @(posedge clk);
        #1;
        if (hold) begin
            funct3 = 3'b000; rs1_val = 32'h0000_1234; rs2_val = 32'h0000_0003;
        end else begin
            start = 1'b0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                res = result;
                stall_at_done = stall;
                break;
            end
            if (stall) stalls++;
        end
        start = 1'b0;
        check({nm, " result"}, res, exp);
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " stall cycles"}, stalls, exp_lat);
        check({nm, " stall at done"}, {31'b0, stall_at_done}, 32'h0);
        @(negedge clk);
        check({nm, " idle after done"}, {30'b0, busy, done}, 32'h0);
    endtask

    initial begin
        bit seen_done;

        vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB}; // MUL 7*-3
        vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE}; // MULHU
        vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}; // MULH -1*-1
        vecs[3]  = '{3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD}; // DIV -20/6
        vecs[4]  = '{3'b110, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE}; // REM -20/6
        vecs[5]  = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}; // DIVU
        vecs[6]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF}; // DIVU 5/0
        vecs[7]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005}; // REMU 5/0
        vecs[8]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000}; // DIV overflow
        vecs[9]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}; // REM overflow
        vecs[10] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; // MULHSU -1*(2^32-1)
        vecs[11] = '{3'b000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000}; // MUL by zero
        vecs[12] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000}; // MULH min*min
        vecs[13] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD}; // DIV 7/-2
        vecs[14] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001}; // REM 7/-2
        vecs[15] = '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002}; // REMU 100/7
        vecs[16] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001}; // MULHU 2^16*2^16
        vecs[17] = '{3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001}; // MUL low half

        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; rs1_val = 32'h0; rs2_val = 32'h0;
        repeat (3) @(negedge clk);
        check("reset outputs", {29'b0, stall, busy, done}, 32'h0);
        check("reset result", result, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        // Start held through RUN and DONE must not disturb or retrigger the op.
        run_op("hold start", 3'b100, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 1'b1);

        // Start and flush together: no operation begins.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b101; rs1_val = 32'h9; rs2_val = 32'h2;
        #1;
        check("start+flush stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        check("start+flush busy", {30'b0, busy, done}, 32'h0);
        start = 1'b0; flush = 1'b0;

        // Flush at RUN cycle 10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'h0000_1234; rs2_val = 32'h0000_5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("flush pre busy", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        @(negedge clk);
        check("flush post state", {30'b0, busy, done}, 32'h0);
        flush = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("flush no done", {31'b0, seen_done}, 32'h0);
        run_op("after flush", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);

        // Reset at RUN cycle 5; result currently holds the previous nonzero value.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset flags", {29'b0, stall, busy, done}, 32'h0);
        check("midrun reset result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
